// File: rtl/source_out_arb_if.sv
// source_out_arb_if: requester, downstream and status signals of the burst arbiter
interface source_out_arb_if #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int LW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ*LW-1:0] req_len;
  logic [NREQ*DW-1:0] src_data;
  logic [NREQ-1:0]    src_valid;
  logic [NREQ-1:0]    src_ready;
  logic               out_en;
  logic [NREQ-1:0]    grant;
  logic               busy;
  logic               data_en;
  logic [DW-1:0]      data_out;
  logic               burst_done;
  logic [1:0]         burst_id;
  modport master (
    output req, req_len, src_data, src_valid, out_en,
    input  src_ready, grant, busy, data_en, data_out, burst_done, burst_id
  );
  modport slave (
    input  req, req_len, src_data, src_valid, out_en,
    output src_ready, grant, busy, data_en, data_out, burst_done, burst_id
  );
endinterface

// File: rtl/source_out_arb.sv
// source_out_arb: round-robin burst arbiter sharing one registered output word path among four requesters
module source_out_arb #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int LW   = 8
) (
  input logic             clk,
  input logic             nRST,
  source_out_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GRANT, XFER, DONE} state_t;
  state_t          state, state_nx;
  logic [1:0]      sel, rr_ptr, pick;
  logic            found;
  logic [NREQ-1:0] elig, sel_oh;
  logic [LW-1:0]   cnt, sel_len;
  logic [DW-1:0]   sel_data;
  logic            acc;
  assign sel_oh         = NREQ'(1) << sel;
  assign sel_data       = bus.src_data[sel*DW +: DW];
  assign sel_len        = bus.req_len[sel*LW +: LW];
  assign acc            = (state == XFER) & bus.out_en & bus.src_valid[sel];
  assign bus.src_ready  = (state == XFER & bus.out_en) ? sel_oh : '0;
  assign bus.busy       = state != IDLE;
  assign bus.burst_done = state == DONE;
  assign bus.burst_id   = sel;
  // a requester is eligible only while requesting with a non-zero length
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) elig[i] = bus.req[i] & |bus.req_len[i*LW +: LW];
  end
  // first eligible requester at or after rr_ptr; lowest offset wins since it is assigned last
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (elig[rr_ptr + 2'(k)]) begin
        pick  = rr_ptr + 2'(k);
        found = 1'b1;
      end
  end
  // state register, cleared asynchronously so a burst aborts without a done pulse
  always_ff @(posedge clk or negedge nRST)
    if (!nRST) state <= IDLE;
    else state <= state_nx;
  // next state: the last accepted word or a dropped request both end the burst
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = found ? GRANT : IDLE;
      GRANT:   state_nx = XFER;
      XFER:    state_nx = ((acc & cnt == LW'(1)) | ~bus.req[sel]) ? DONE : XFER;
      default: state_nx = IDLE;
    endcase
  end
  // owner selection, word count, registered output word and round-robin pointer
  always_ff @(posedge clk or negedge nRST)
    if (!nRST) begin
      bus.grant    <= '0;
      bus.data_en  <= 1'b0;
      bus.data_out <= '0;
      sel          <= '0;
      rr_ptr       <= '0;
      cnt          <= '0;
    end else begin
      bus.data_en <= acc;
      if (acc) bus.data_out <= sel_data;
      if (state == IDLE & found) begin
        sel       <= pick;
        bus.grant <= NREQ'(1) << pick;
      end
      if (state == GRANT) cnt <= sel_len;
      if (acc) cnt <= cnt - 1'b1;
      if (state == DONE) begin
        bus.grant <= '0;
        rr_ptr    <= sel + 1'b1;
      end
    end
endmodule

// File: doc/source_out_arb.md
Name: source_out_arb

Overview:
- Round-robin burst arbiter that shares the single 16-bit source output path among 4 requesters (e.g. read-data, status, ID/config, debug sources).
- Each requester asks for a burst of N words. The arbiter grants one requester at a time and streams its words to a registered data_out/data_en pair.
- Sits directly ahead of the host-facing output stage and drives its data_in/data_en_in.

Parameters:
- NREQ, 4, number of requesters; design and verification are fixed at 4.
- DW, 16, data word width.
- LW, 8, burst length field width per requester.

Ports:
- clk  in  1  system clock
- nRST  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester burst request, level, held until burst_done
- req_len  in  NREQ*LW  burst length in words per requester; slice i = [i*LW +: LW]
- src_data  in  NREQ*DW  word data per requester; slice i = [i*DW +: DW]
- src_valid  in  NREQ  requester i has a word on src_data slice i
- src_ready  out  NREQ  combinational; word accepted this cycle when src_valid[i] & src_ready[i]
- out_en  in  1  downstream enable; 0 pauses transfer without losing state
- grant  out  NREQ  one-hot current owner, registered
- busy  out  1  high in any state other than IDLE
- data_en  out  1  registered word strobe
- data_out  out  DW  registered word
- burst_done  out  1  one-cycle pulse at end of every burst
- burst_id  out  2  index of the requester whose burst just ended; valid while burst_done=1

Behaviour:
- Reset state: state=IDLE, grant=0, busy=0, data_en=0, data_out=0, burst_done=0, burst_id=0, rr_ptr=0, word count=0.
- Reset asserted mid-burst aborts immediately, with no burst_done pulse.
- Eligible requester: req[i]=1 and req_len slice i != 0. Zero-length requests are never granted.
- FSM states: IDLE, GRANT, XFER, DONE.
- IDLE:
  - Scan eligible requesters starting at index rr_ptr, wrapping modulo 4.
  - On finding the first eligible index g, go to GRANT.
  - Stay in IDLE if none is eligible.
- GRANT (1 cycle):
  - Register grant=onehot(g).
  - Latch cnt=req_len slice g.
  - Go to XFER.
  - No transfer occurs in this cycle.
- XFER:
  - src_ready[g] = out_en. All other src_ready bits are 0.
  - On an accepted word: data_out<=src_data slice g, data_en<=1 in the next cycle (1-cycle latency), cnt<=cnt-1.
  - No accepted word: data_en<=0 and data_out holds its last value.
  - Accepted word with cnt=1: go to DONE.
  - req[g] dropping to 0 ends the burst early: go to DONE in the same cycle, and remaining words are discarded.
  - If the last word and req[g] deassertion coincide: the word is transferred and DONE is entered normally (one DONE only).
  - out_en=0 stalls XFER indefinitely; cnt is unchanged.
- DONE (1 cycle):
  - burst_done=1, burst_id=g.
  - grant<=0.
  - rr_ptr<=(g+1) mod 4.
  - data_en follows the XFER rule for the last word, so data_en may be high during DONE.
  - Return to IDLE.
  - Minimum gap between bursts is therefore the DONE, IDLE and GRANT cycles.
- Word count is a free-running cnt with no wrap: req_len=255 transfers exactly 255 words.
- req changes on non-granted requesters during a burst have no effect until the next IDLE scan.
- src_ready is 0 in IDLE, GRANT and DONE regardless of out_en.

Test Plan:
- Single requester: req[1]=1, len=3, src_valid=1, out_en=1, data 0xA001/0xA002/0xA003 → grant=0010 after 1 cycle; data_en high for 3 consecutive cycles with those values; burst_done with burst_id=1 one cycle after the last acceptance.
- Round robin: req=1111, all len=2 → grant order 0,1,2,3,0; each burst yields exactly 2 data_en pulses.
- Stall: during XFER hold out_en=0 for 5 cycles → src_ready=0, data_en=0, data_out unchanged; on resume the remaining count completes with no word lost or duplicated.
- Early abort: len=10, drop req after 4 accepted words → exactly 4 data_en pulses, burst_done; next requester is granted. Coincident last-word/drop case → exactly len words, single burst_done.
- Zero length and gaps: req[2]=1 with len=0 alongside req[3]=1 with len=1 → requester 2 never granted, requester 3 granted. Toggling src_valid per cycle → data_en mirrors accepted words only.
- Reset mid-burst: assert nRST low after 2 of 5 words → all outputs 0 asynchronously, no burst_done; after release, arbitration restarts at requester 0.
